// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS32 instruction-fetch stage with IF/ID pipeline register
// Optional perf counters (fetch/stall/flush) are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_write_enable,
  input  logic        IF_ID_write_enable,
  input  logic        branch_taken_EX,
  input  logic [31:0] branch_target_EX,
  input  logic        jump_ID,
  input  logic [31:0] jump_target_ID,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_ID,
  output logic [31:0] pc_plus4_ID,
  output logic        valid_ID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        jump_redirect;
  logic        flush;

  assign pc_plus4      = pc + 32'd4;
  assign imem_addr     = pc;
  // A taken branch in EX means the jump now in ID is on the wrong path.
  assign jump_redirect = jump_ID & PC_write_enable & ~branch_taken_EX;
  assign flush         = branch_taken_EX | jump_redirect;

  always_comb begin
    next_pc = pc;
    if (branch_taken_EX)
      next_pc = branch_target_EX & ~32'h3;
    else if (jump_redirect)
      next_pc = jump_target_ID & ~32'h3;
    else if (PC_write_enable && !jump_ID)
      next_pc = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else
      pc <= next_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_ID    <= NOP_INSTR;
      pc_plus4_ID <= 32'h0;
      valid_ID    <= 1'b0;
    end else if (flush) begin
      instr_ID    <= NOP_INSTR;
      pc_plus4_ID <= 32'h0;
      valid_ID    <= 1'b0;
    end else if (IF_ID_write_enable) begin
      instr_ID    <= imem_rdata;
      pc_plus4_ID <= pc_plus4;
      valid_ID    <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (!flush && IF_ID_write_enable && fetch_cnt != 32'hFFFF_FFFF)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (!flush && !IF_ID_write_enable && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against a behavioural model
// Counter checks are compiled in when IF_PERF_CNT_EN is defined.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        PC_write_enable = 1'b0;
  logic        IF_ID_write_enable = 1'b0;
  logic        branch_taken_EX = 1'b0;
  logic [31:0] branch_target_EX = 32'h0;
  logic        jump_ID = 1'b0;
  logic [31:0] jump_target_ID = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_ID;
  logic [31:0] pc_plus4_ID;
  logic        valid_ID;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
  longint unsigned m_fetch = 0, m_stall = 0, m_flush = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 0;

  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pp4 = 32'h0;
  logic        m_valid = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .PC_write_enable(PC_write_enable), .IF_ID_write_enable(IF_ID_write_enable),
    .branch_taken_EX(branch_taken_EX), .branch_target_EX(branch_target_EX),
    .jump_ID(jump_ID), .jump_target_ID(jump_target_ID),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_ID(instr_ID), .pc_plus4_ID(pc_plus4_ID), .valid_ID(valid_ID)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("valid_ID", {31'b0, valid_ID}, {31'b0, m_valid});
      chk("instr_ID", instr_ID, m_instr);
      if (m_valid) chk("pc_plus4_ID", pc_plus4_ID, m_pp4);
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, m_fetch[31:0]);
      chk("stall_cnt", stall_cnt, m_stall[31:0]);
      chk("flush_cnt", flush_cnt, m_flush[31:0]);
`endif
    end
  end

  // One clock edge: apply inputs, predict the architectural effect, wait for the edge.
  task automatic step(input logic pcw, input logic ifw, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    logic [31:0] n_pc, n_instr, n_pp4;
    logic        n_valid;
    PC_write_enable    = pcw;
    IF_ID_write_enable = ifw;
    branch_taken_EX    = br;
    branch_target_EX   = bt;
    jump_ID            = jp;
    jump_target_ID     = jt;
    n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid;
    if (br || (jp && pcw)) begin
      n_pc = br ? {bt[31:2], 2'b00} : {jt[31:2], 2'b00};
      n_instr = 32'h0; n_valid = 1'b0;
`ifdef IF_PERF_CNT_EN
      m_flush++;
`endif
    end else begin
      if (pcw && !jp) n_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
      if (ifw) begin
        n_instr = mem_word(m_pc);
        n_pp4   = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        n_valid = 1'b1;
`ifdef IF_PERF_CNT_EN
        m_fetch++;
`endif
      end else begin
`ifdef IF_PERF_CNT_EN
        m_stall++;
`endif
      end
    end
    @(posedge clk);
    m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid;
    #1;
  endtask

  initial begin
    logic br, jp, en;
    // T1: asynchronous reset in the middle of a cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    #1;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, valid_ID}, 32'h0);
    chk("rst_instr", instr_ID, 32'h0);
    chk("rst_pp4", pc_plus4_ID, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    check_en = 1;
    step(1, 1, 0, 0, 0, 0);
    chk("t1_pp4_a", pc_plus4_ID, 32'h4);
    chk("t1_instr_a", instr_ID, 32'h1357_9BDF);
    step(1, 1, 0, 0, 0, 0);
    chk("t1_pp4_b", pc_plus4_ID, 32'h8);
    step(1, 1, 0, 0, 0, 0);
    chk("t1_pp4_c", pc_plus4_ID, 32'hC);
    chk("t1_instr_c", instr_ID, mem_word(32'h8));
    // T2: load-use stall at PC=0x10
    step(1, 1, 0, 0, 0, 0);
    chk("t2_pc_pre", imem_addr, 32'h10);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_pc_hold", imem_addr, 32'h10);
    chk("t2_pp4_hold", pc_plus4_ID, 32'h10);
    step(1, 1, 0, 0, 0, 0);
    chk("t2_instr", instr_ID, mem_word(32'h10));
    chk("t2_pc", imem_addr, 32'h14);
    // T3: branch overrides a stall
    step(0, 0, 1, 32'h100, 0, 0);
    chk("t3_pc", imem_addr, 32'h100);
    chk("t3_valid", {31'b0, valid_ID}, 32'h0);
    chk("t3_instr", instr_ID, 32'h0);
    step(1, 1, 0, 0, 0, 0);
    chk("t3_instr_b", instr_ID, mem_word(32'h100));
    chk("t3_pp4_b", pc_plus4_ID, 32'h104);
`ifdef IF_PERF_CNT_EN
    chk("t6_fetch", fetch_cnt, 32'd6);
    chk("t6_stall", stall_cnt, 32'd1);
    chk("t6_flush", flush_cnt, 32'd1);
`endif
    // T4: stall beats jump, then jump retried; branch beats jump
    step(0, 0, 0, 0, 1, 32'h200);
    chk("t4_pc_hold", imem_addr, 32'h104);
    step(1, 1, 0, 0, 1, 32'h200);
    chk("t4_pc_jump", imem_addr, 32'h200);
    chk("t4_valid", {31'b0, valid_ID}, 32'h0);
    step(1, 1, 1, 32'h400, 1, 32'h300);
    chk("t4_br_wins", imem_addr, 32'h400);
    // T5: wrap and alignment
    step(1, 1, 1, 32'hFFFF_FFFC, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("t5_wrap_pc", imem_addr, 32'h0);
    chk("t5_wrap_pp4", pc_plus4_ID, 32'h0);
    step(1, 1, 1, 32'h103, 0, 0);
    chk("t5_align", imem_addr, 32'h100);
    // Enables disagree: PC advances, IF/ID held
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("split_pc", imem_addr, 32'h108);
    chk("split_pp4", pc_plus4_ID, 32'h104);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      br = ($urandom_range(7) == 0);
      jp = ($urandom_range(5) == 0);
      en = ($urandom_range(3) != 0);
      step(en, en, br, $urandom, jp, $urandom);
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
